// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor: 10 forward key-expansion cycles followed by 10 inverse rounds.
// Optional key cache enabled by defining AES_DEC_KEY_CACHE_EN (repeat key skips expansion).
module aes_128_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q;
    logic [127:0] s_q;
    logic [127:0] k_q;
    logic [127:0] k_fwd, k_prev, core;
    logic         cache_hit;
    logic [127:0] cache_k10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Field inverse computed as a^254, which maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, p;
        sq = a;
        p  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            p  = gf_mul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        case (i)
            4'd0: r = 8'h01;
            4'd1: r = 8'h02;
            4'd2: r = 8'h04;
            4'd3: r = 8'h08;
            4'd4: r = 8'h10;
            4'd5: r = 8'h20;
            4'd6: r = 8'h40;
            4'd7: r = 8'h80;
            4'd8: r = 8'h1b;
            4'd9: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Byte i sits at bits [127-8i -: 8], row i%4, column i/4.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sub_byte(s[127-8*(4*((c-r)&3)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                     ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction

    assign k_fwd  = key_step_fwd(k_q, rcon(cnt_q));
    assign k_prev = key_step_inv(k_q, rcon(4'd9 - cnt_q));
    assign core   = inv_shift_sub(s_q) ^ k_prev;

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_valid_q;
    logic [127:0] cache_key_q, cache_k10_q;

    assign cache_hit = cache_valid_q && (key == cache_key_q);
    assign cache_k10 = cache_k10_q;

    // A miss invalidates at accept so a half-filled entry is never matched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_k10_q   <= '0;
        end else begin
            if (state_q == IDLE && in_valid && !cache_hit) begin
                cache_valid_q <= 1'b0;
                cache_key_q   <= key;
            end
            if (state_q == KEXP && cnt_q == 4'd9) begin
                cache_valid_q <= 1'b1;
                cache_k10_q   <= k_fwd;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_k10 = '0;
`endif

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = cache_hit ? ROUND : KEXP;
            end
            KEXP:    if (cnt_q == 4'd9) state_d = ROUND;
            ROUND:   if (cnt_q == 4'd9) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            plaintext <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    cnt_q <= '0;
                    s_q   <= cache_hit ? (ciphertext ^ cache_k10) : ciphertext;
                    k_q   <= cache_hit ? cache_k10 : key;
                end
                KEXP: begin
                    k_q <= k_fwd;
                    if (cnt_q == 4'd9) begin
                        s_q   <= s_q ^ k_fwd;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    k_q <= k_prev;
                    if (cnt_q == 4'd9) begin
                        plaintext <= core;
                        out_valid <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        s_q   <= inv_mix_columns(core);
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Self-checking bench for aes_128_decrypt_iter: table-based inverse-cipher reference model,
// latency/handshake model, FIPS-197 vectors. Cache tests follow AES_DEC_KEY_CACHE_EN.
module tb_aes_128_decrypt_iter;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int LAT_MISS = 20;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int LAT_HIT = 10;
`else
    localparam int LAT_HIT = 20;
`endif

    aes_128_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ciphertext(ciphertext),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plaintext (plaintext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox     [256];
    logic [7:0] inv_sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa, bb;
        r = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return r;
    endfunction

    // S-box built by walking the multiplicative group with generator 3 and its inverse.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = i[7:0];
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [31:0]  w   [44];
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int i = 0; i < 16; i++) tmp[i] = st[i];
            for (int i = 0; i < 16; i++)
                st[i] = inv_sbox[tmp[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) tmp[r] = st[4*c+r];
                    st[4*c+0] = gmul(tmp[0], 14) ^ gmul(tmp[1], 11) ^ gmul(tmp[2], 13) ^ gmul(tmp[3], 9);
                    st[4*c+1] = gmul(tmp[0], 9)  ^ gmul(tmp[1], 14) ^ gmul(tmp[2], 11) ^ gmul(tmp[3], 13);
                    st[4*c+2] = gmul(tmp[0], 13) ^ gmul(tmp[1], 9)  ^ gmul(tmp[2], 14) ^ gmul(tmp[3], 11);
                    st[4*c+3] = gmul(tmp[0], 11) ^ gmul(tmp[1], 13) ^ gmul(tmp[2], 9)  ^ gmul(tmp[3], 14);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Transaction-level timing model: a busy countdown, not a state machine.
    logic         m_in_ready, m_out_valid, m_hit;
    logic [127:0] m_pt;
    int           m_left;
`ifdef AES_DEC_KEY_CACHE_EN
    logic         m_cv;
    logic [127:0] m_ckey, m_pend;
    assign m_hit = m_cv && (key == m_ckey);
`else
    assign m_hit = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_ready  <= 1'b1;
            m_out_valid <= 1'b0;
            m_left      <= 0;
            m_pt        <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            m_cv        <= 1'b0;
`endif
        end else if (m_in_ready && in_valid) begin
            m_in_ready <= 1'b0;
            m_pt       <= model_decrypt(ciphertext, key);
            m_left     <= m_hit ? 10 : 20;
`ifdef AES_DEC_KEY_CACHE_EN
            if (!m_hit) begin
                m_cv   <= 1'b0;
                m_pend <= key;
            end
`endif
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_out_valid <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (m_left == 11) begin
                m_cv   <= 1'b1;
                m_ckey <= m_pend;
            end
`endif
        end else if (m_out_valid && out_ready) begin
            m_out_valid <= 1'b0;
            m_in_ready  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc in_ready", in_ready, m_in_ready);
            check("cyc out_valid", out_valid, m_out_valid);
            if (m_out_valid) check("cyc plaintext", plaintext, m_pt);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_txn(input string tag, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp_pt, input int exp_lat, input int hold,
                           input bit scramble, input int abort_at);
        int n;
        @(negedge clk);
        check({tag, " in_ready before accept"}, in_ready, 1);
        in_valid   = 1'b1;
        ciphertext = ct;
        key        = k;
        out_ready  = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            if (scramble) begin
                ciphertext = rand128();
                key        = rand128();
            end
            @(posedge clk); #1;
            n++;
            if (abort_at > 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " abort out_valid"}, out_valid, 0);
                check({tag, " abort plaintext"}, plaintext, 0);
                check({tag, " abort in_ready"}, in_ready, 1);
                @(negedge clk); #2;
                rst_n = 1'b1;
                return;
            end
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " plaintext"}, plaintext, exp_pt);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid   = i[0];
                ciphertext = rand128();
                key        = rand128();
                @(posedge clk); #1;
                check({tag, " hold plaintext"}, plaintext, exp_pt);
                check({tag, " hold out_valid"}, out_valid, 1);
                check({tag, " hold in_ready"}, in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " handoff out_valid"}, out_valid, 0);
        check({tag, " handoff in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ciphertext = '0;
        key        = '0;
        build_tables();
        check("sbox[00]", sbox[8'h00], 8'h63);
        check("sbox[53]", sbox[8'h53], 8'hed);
        check("model C.1", model_decrypt(C1_CT, C1_KEY), C1_PT);
        check("model App.B", model_decrypt(B_CT, B_KEY), B_PT);

        #3 rst_n = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset plaintext", plaintext, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        run_txn("c1 first",    C1_CT, C1_KEY, C1_PT, LAT_MISS, 0,  1'b0, 0);
        run_txn("c1 repeat",   C1_CT, C1_KEY, C1_PT, LAT_HIT,  0,  1'b0, 0);
        run_txn("appb hold",   B_CT,  B_KEY,  B_PT,  LAT_MISS, 15, 1'b0, 0);
        run_txn("c1 scramble", C1_CT, C1_KEY, C1_PT, LAT_MISS, 0,  1'b1, 0);
        run_txn("c1 abort",    C1_CT, C1_KEY, C1_PT, LAT_HIT,  0,  1'b0, LAT_HIT - 5);
        repeat (25) @(negedge clk);
        check("post abort out_valid", out_valid, 0);
        run_txn("c1 after rst", C1_CT, C1_KEY, C1_PT, LAT_MISS, 0, 1'b0, 0);
        run_txn("appb final",   B_CT,  B_KEY,  B_PT,  LAT_MISS, 0, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
